// File: rtl/controle_seq.sv
// Purpose : command sequencer driving X/Y/Z register and ULA control codes.
// Latency : ULA op done at c7, shift done at cN+1, clear done at c2 (from accept edge).
// Backpr. : cmd_ready only in IDLE; operand waits indefinitely for operand_valid.
module controle_seq #(
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_mode,
   input  logic [2:0]        cmd_op,
   input  logic [CNT_W-1:0]  cmd_count,
   input  logic              operand_valid,
   output logic              operand_ack,
   output logic [CTRL_W-1:0] Tx,
   output logic [CTRL_W-1:0] Ty,
   output logic [CTRL_W-1:0] Tz,
   output logic [CTRL_W-1:0] Tula,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Register control codes
   localparam logic [2:0] C_HOLD   = 3'b000;
   localparam logic [2:0] C_LOAD   = 3'b001;
   localparam logic [2:0] C_SHIFTR = 3'b010;
   localparam logic [2:0] C_SHIFTL = 3'b011;
   localparam logic [2:0] C_RESET  = 3'b100;

   // ULA codes; 111 is not a real operation and falls back to ADD
   localparam logic [2:0] OP_ADD     = 3'b000;
   localparam logic [2:0] OP_ILLEGAL = 3'b111;

   // Command modes
   localparam logic [1:0] M_ULA    = 2'b00;
   localparam logic [1:0] M_SHR    = 2'b01;
   localparam logic [1:0] M_SHL    = 2'b10;
   localparam logic [1:0] M_CLEAR  = 2'b11;

   typedef enum logic [3:0] {
      S_CLR    = 4'd0,
      S_IDLE   = 4'd1,
      S_WAIT_A = 4'd2,
      S_LD_A   = 4'd3,
      S_XFER   = 4'd4,
      S_WAIT_B = 4'd5,
      S_LD_B   = 4'd6,
      S_EXEC   = 4'd7,
      S_SHIFT  = 4'd8,
      S_DONE   = 4'd9
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Distinguishes a commanded clear (ends with done) from a reset clear
   logic             clr_cmd_q, clr_cmd_d;

   // Zero-extend a 3-bit code to the output width
   function automatic logic [CTRL_W-1:0] ext(input logic [2:0] c);
      logic [CTRL_W-1:0] r;
      r      = '0;
      r[2:0] = c;
      return r;
   endfunction

   // State and latched-command registers; reset discards any pending command
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_CLR;
         mode_q    <= '0;
         op_q      <= '0;
         cnt_q     <= '0;
         clr_cmd_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         clr_cmd_q <= clr_cmd_d;
      end
   end

   // Next-state logic, command latching and shift counter
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      clr_cmd_d = clr_cmd_q;

      case (state_q)
         S_CLR: begin
            state_d   = clr_cmd_q ? S_DONE : S_IDLE;
            clr_cmd_d = 1'b0;
         end

         S_IDLE: begin
            if (cmd_valid) begin
               mode_d = cmd_mode;
               op_d   = cmd_op;
               cnt_d  = cmd_count;
               case (cmd_mode)
                  M_ULA:   state_d = S_WAIT_A;
                  M_SHR,
                  M_SHL:   state_d = (cmd_count != '0) ? S_SHIFT : S_DONE;
                  M_CLEAR: begin
                     state_d   = S_CLR;
                     clr_cmd_d = 1'b1;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end

         S_WAIT_A: if (operand_valid) state_d = S_LD_A;
         S_LD_A:   state_d = S_XFER;
         S_XFER:   state_d = S_WAIT_B;
         S_WAIT_B: if (operand_valid) state_d = S_LD_B;
         S_LD_B:   state_d = S_EXEC;
         S_EXEC:   state_d = S_DONE;

         S_SHIFT: begin
            // Counter saturates at zero; the last shift is the one seen with count 1
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_d = S_DONE;
         end

         S_DONE:   state_d = S_IDLE;

         default:  state_d = S_CLR;
      endcase
   end

   // Moore output decode from the registered state
   always_comb begin
      Tx          = ext(C_HOLD);
      Ty          = ext(C_HOLD);
      Tz          = ext(C_HOLD);
      Tula        = ext(OP_ADD);
      operand_ack = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      cmd_ready   = (state_q == S_IDLE);
      busy        = (state_q != S_IDLE);

      case (state_q)
         S_CLR: begin
            Tx = ext(C_RESET);
            Ty = ext(C_RESET);
            Tz = ext(C_RESET);
         end
         S_LD_A, S_LD_B: begin
            Tx          = ext(C_LOAD);
            operand_ack = 1'b1;
         end
         S_XFER: Ty = ext(C_LOAD);
         S_EXEC: begin
            Tz = ext(C_LOAD);
            if (op_q == OP_ILLEGAL) begin
               Tula = ext(OP_ADD);
               err  = 1'b1;
            end else begin
               Tula = ext(op_q);
            end
         end
         S_SHIFT: Ty = ext((mode_q == M_SHL) ? C_SHIFTL : C_SHIFTR);
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/controle_seq.md
Name: controle_seq

Overview:
- Parametrised command-driven sequencer for the X/Y/Z register + ULA datapath.
- Accepts one command at a time over a valid/ready handshake.
- Drives per-register control codes (Tx, Ty, Tz) and the ULA operation code (Tula) through multi-cycle sequences: binary ULA operation, repeated Y shift, global clear.
- Pulls operands from the external operand bus with a valid/ack handshake; signals completion with a one-cycle done pulse.

Parameters:
- CTRL_W, 4, width of Tx/Ty/Tz/Tula; the 3-bit codes are zero-extended, CTRL_W >= 3.
- CNT_W, 4, width of the shift repeat count.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_mode  in  2  00 ULA op, 01 shift Y right, 10 shift Y left, 11 clear all.
- cmd_op  in  3  ULA code for mode 00: ADD 000, SUB 001, MAIOR 010, MENOR 011, IGUAL 100, XOR 101, AND 110.
- cmd_count  in  CNT_W  shift repeat count for modes 01/10.
- operand_valid  in  1  external operand bus holds a valid operand.
- operand_ack  out  1  operand consumed this cycle.
- Tx, Ty, Tz  out  CTRL_W  register control: HOLD 000, LOAD 001, SHIFTR 010, SHIFTL 011, RESET 100.
- Tula  out  CTRL_W  ULA operation code.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse: illegal cmd_op 111 accepted.

Behaviour:
- All outputs are Moore-decoded from registered state.
- Default in every state unless listed: Tx/Ty/Tz=HOLD, Tula=ADD, operand_ack=0, done=0, err=0.
- Reset (any cycle, including mid-command): next state CLR; the pending command, latched op and count are discarded; done is not pulsed for the aborted command.
- States and transitions:
  - CLR: Tx=Ty=Tz=RESET. After reset -> IDLE; when entered from a mode 11 command -> DONE.
  - IDLE: cmd_ready=1. On cmd_valid, latch mode/op/count (handshake completes this edge), then branch: mode 00 -> WAIT_A; 01/10 -> SHIFT if count != 0, else DONE; 11 -> CLR.
  - WAIT_A: -> LD_A when operand_valid=1; otherwise stay indefinitely.
  - LD_A: Tx=LOAD, operand_ack=1 -> XFER.
  - XFER: Ty=LOAD (Y <- X) -> WAIT_B.
  - WAIT_B: -> LD_B when operand_valid=1.
  - LD_B: Tx=LOAD, operand_ack=1 -> EXEC.
  - EXEC: Tz=LOAD, Tula=latched op -> DONE.
  - SHIFT: Ty=SHIFTR (mode 01) or SHIFTL (mode 10). The internal counter loads count on accept and decrements each SHIFT cycle; leave for DONE after exactly count SHIFT cycles.
  - DONE: done=1 -> IDLE.
- Illegal op 111: accepted normally, executed as ADD; err pulses in the EXEC cycle.
- cmd_ready=0 in every state but IDLE. A cmd_valid outside IDLE is ignored and must be held by the master.
- operand_valid is ignored outside WAIT_A/WAIT_B. Each operand is consumed at most once; operand_ack lasts exactly one cycle per load.
- Latency, measured from the accept edge (cycle 0) with operand_valid held high:
  - mode 00: WAIT_A c1, LD_A c2, XFER c3, WAIT_B c4, LD_B c5, EXEC c6, DONE c7.
  - shift: SHIFT c1..cN, DONE cN+1.
  - clear: CLR c1, DONE c2.
- Maximum count 2^CNT_W-1; no wrap-around, since the counter stops at zero.
- Back-to-back commands: the next accept occurs at the earliest in the IDLE cycle after DONE.

Test Plan:
- Reset held 2 cycles then released -> one CLR cycle with Tx=Ty=Tz=RESET, then IDLE with cmd_ready=1, busy=0, Tula=ADD.
- Mode 00, op SUB (001), operand_valid tied high -> exact sequence LD_A (Tx=LOAD, ack) c2, XFER (Ty=LOAD) c3, LD_B c5, EXEC Tz=LOAD Tula=001 c6, done c7; exactly 2 ack pulses.
- Mode 00 with operand_valid low 5 cycles in WAIT_B -> outputs stay HOLD, no ack; LD_B follows the first cycle operand_valid=1.
- Mode 10, count=3 -> Ty=SHIFTL for exactly 3 cycles, done on c4; count=0 -> no shift, done on c1; count=15 (CNT_W=4) -> 15 SHIFTR/SHIFTL cycles.
- Op 111 -> EXEC drives Tula=000, err=1 for one cycle, done follows; mode 11 -> CLR all RESET, done next cycle.
- Reset asserted during SHIFT with count=10 after 4 shifts -> next cycle CLR, then IDLE, no done pulse; cmd_valid held during busy is not accepted until IDLE.
